// File: rtl/fp32_div_iter.sv
// fp32_div_iter: iterative radix-2 restoring FP32 divider feeding the FP32 rounding stage.
// Define FP32_DIV_SUBNORM_EN to normalize subnormal operands; otherwise they are flushed to zero.
module fp32_div_iter (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic [4:0]  in_roundingMode,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_invalidExc,
  output logic        out_infiniteExc,
  output logic        out_isInf,
  output logic        out_isZero,
  output logic        out_isNaN,
  output logic [24:0] out_sigPlus,
  output logic [9:0]  out_exp,
  output logic        out_sign,
  output logic [4:0]  out_roundingMode
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ITER = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [4:0] LAST_STEP = 5'd24;

  typedef struct packed {
    logic        nan;
    logic        snan;
    logic        inf;
    logic        zero;
    logic [23:0] sig;
    logic [9:0]  exp;
  } opInfo_t;

`ifdef FP32_DIV_SUBNORM_EN
  function automatic logic [4:0] leadZeros(input logic [23:0] v);
    logic [4:0] n;
    n = 5'd24;
    for (int i = 0; i < 24; i++) begin
      if (v[i]) n = 5'(23 - i);
    end
    return n;
  endfunction
`endif

  function automatic opInfo_t decodeOp(input logic [30:0] x);
    opInfo_t     d;
    logic [7:0]  e;
    logic [22:0] f;
`ifdef FP32_DIV_SUBNORM_EN
    logic [4:0]  lz;
    lz = 5'd0;
`endif
    e = x[30:23];
    f = x[22:0];
    d = '0;
    if (e == 8'hFF) begin
      d.nan  = (f != '0);
      d.snan = (f != '0) && !f[22];
      d.inf  = (f == '0);
    end else if (e == 8'h00) begin
`ifdef FP32_DIV_SUBNORM_EN
      if (f == '0) begin
        d.zero = 1'b1;
      end else begin
        // Shift so the leading one lands in the hidden-bit position.
        lz    = leadZeros({1'b0, f});
        d.sig = {1'b0, f} << lz;
        d.exp = 10'(-126) - {5'd0, lz};
      end
`else
      d.zero = 1'b1;
`endif
    end else begin
      d.sig = {1'b1, f};
      d.exp = {2'b00, e} - 10'd127;
    end
    return d;
  endfunction

  logic [1:0]  state;
  logic [25:0] rem;
  logic [23:0] quo;
  logic [23:0] divisor;
  logic [4:0]  stepCnt;
  logic        stickyBit;

  opInfo_t decA;
  opInfo_t decB;
  assign decA = decodeOp(in_a[30:0]);
  assign decB = decodeOp(in_b[30:0]);

  logic spInvalid, spInfinite, spInf, spZero, spNaN, anySpecial;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    spInvalid  = 1'b0;
    spInfinite = 1'b0;
    spInf      = 1'b0;
    spZero     = 1'b0;
    spNaN      = 1'b0;
    if (decA.nan || decB.nan) begin
      spNaN     = 1'b1;
      spInvalid = decA.snan || decB.snan;
    end else if ((decA.zero && decB.zero) || (decA.inf && decB.inf)) begin
      spInvalid = 1'b1;
      spNaN     = 1'b1;
    end else if (decA.inf || decB.zero) begin
      spInf      = 1'b1;
      spInfinite = decB.zero && !decA.inf;
    end else if (decA.zero || decB.inf) begin
      spZero = 1'b1;
    end
  end

  assign anySpecial = spNaN || spInf || spZero;

  logic        sigALess;
  logic [25:0] remInit;
  logic [9:0]  expInit;

  assign sigALess = (decA.sig < decB.sig);
  assign remInit  = sigALess ? {1'b0, decA.sig, 1'b0} : {2'b00, decA.sig};
  assign expInit  = decA.exp - decB.exp - {9'd0, sigALess};

  logic        qBit;
  logic [25:0] remSub;
  logic [25:0] remNext;

  always_comb begin
    qBit    = (rem >= {2'b00, divisor});
    remSub  = qBit ? (rem - {2'b00, divisor}) : rem;
    remNext = {remSub[24:0], 1'b0};
  end

  // The first quotient bit is always 1 and shifts out of the top by the final step.
  assign out_sigPlus = {quo, stickyBit};
  assign in_ready    = (state == IDLE);

  // Special results carry one of these classification flags and skip the iteration.
  logic specialPath;
  assign specialPath = out_isNaN || out_isInf || out_isZero;

  // NOTE: sequential state uses non-blocking assignments only; datapath registers are
  // reset as well so every output reads zero straight out of reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= IDLE;
      rem              <= '0;
      quo              <= '0;
      divisor          <= '0;
      stepCnt          <= '0;
      stickyBit        <= 1'b0;
      out_valid        <= 1'b0;
      out_invalidExc   <= 1'b0;
      out_infiniteExc  <= 1'b0;
      out_isInf        <= 1'b0;
      out_isZero       <= 1'b0;
      out_isNaN        <= 1'b0;
      out_exp          <= '0;
      out_sign         <= 1'b0;
      out_roundingMode <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            state            <= ITER;
            rem              <= remInit;
            quo              <= '0;
            divisor          <= decB.sig;
            stepCnt          <= '0;
            stickyBit        <= 1'b0;
            out_invalidExc   <= spInvalid;
            out_infiniteExc  <= spInfinite;
            out_isInf        <= spInf;
            out_isZero       <= spZero;
            out_isNaN        <= spNaN;
            out_exp          <= anySpecial ? 10'd0 : expInit;
            out_sign         <= in_a[31] ^ in_b[31];
            out_roundingMode <= in_roundingMode;
          end
        end
        ITER: begin
          if (specialPath) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end else begin
            rem     <= remNext;
            quo     <= {quo[22:0], qBit};
            stepCnt <= stepCnt + 5'd1;
            if (stepCnt == LAST_STEP) begin
              stickyBit <= (remSub != '0);
              state     <= DONE;
              out_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp32_div_iter.sv
// tb_fp32_div_iter: directed self-checking bench for fp32_div_iter with hand-computed results.
// Honors FP32_DIV_SUBNORM_EN to select the expected subnormal behaviour.
module tb_fp32_div_iter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic [4:0]  in_roundingMode = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_invalidExc;
  logic        out_infiniteExc;
  logic        out_isInf;
  logic        out_isZero;
  logic        out_isNaN;
  logic [24:0] out_sigPlus;
  logic [9:0]  out_exp;
  logic        out_sign;
  logic [4:0]  out_roundingMode;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  always #5 clock = ~clock;

  fp32_div_iter dut (
    .clock           (clock),
    .reset           (reset),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_a            (in_a),
    .in_b            (in_b),
    .in_roundingMode (in_roundingMode),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_invalidExc  (out_invalidExc),
    .out_infiniteExc (out_infiniteExc),
    .out_isInf       (out_isInf),
    .out_isZero      (out_isZero),
    .out_isNaN       (out_isNaN),
    .out_sigPlus     (out_sigPlus),
    .out_exp         (out_exp),
    .out_sign        (out_sign),
    .out_roundingMode(out_roundingMode)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expVal);
    total++;
    assert (obs === expVal) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expVal);
    end
  endtask

  // flags = {invalidExc, infiniteExc, isInf, isZero, isNaN}
  task automatic expectResult(input string tag, input logic [4:0] flags, input logic [24:0] sig,
                              input logic [9:0] ex, input logic sign, input logic [4:0] rm);
    check({tag, " flags"}, {out_invalidExc, out_infiniteExc, out_isInf, out_isZero, out_isNaN}, flags);
    check({tag, " sigPlus"}, out_sigPlus, sig);
    check({tag, " exp"}, out_exp, ex);
    check({tag, " sign"}, out_sign, sign);
    check({tag, " rm"}, out_roundingMode, rm);
  endtask

  // Presents one request for exactly one accepting edge, then scrambles the inputs.
  task automatic issue(input string tag, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rm);
    @(negedge clock);
    in_a            = a;
    in_b            = b;
    in_roundingMode = rm;
    in_valid        = 1'b1;
    check({tag, " in_ready"}, in_ready, 1'b1);
    @(posedge clock);
    #1;
    in_valid        = 1'b0;
    in_a            = 32'hDEADBEEF;
    in_b            = 32'h12345678;
    in_roundingMode = 5'h1F;
  endtask

  task automatic waitValid(input string tag, input int lat);
    repeat (lat - 1) @(posedge clock);
    #1 check({tag, " early"}, out_valid, 1'b0);
    @(posedge clock);
    #1 check({tag, " latency"}, out_valid, 1'b1);
  endtask

  task automatic finishOp(input string tag);
    @(negedge clock);
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b0;
    check({tag, " valid drop"}, out_valid, 1'b0);
    check({tag, " ready back"}, in_ready, 1'b1);
  endtask

  task automatic runOp(input string tag, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rm,
                       input int lat, input logic [4:0] flags, input logic [24:0] sig,
                       input logic [9:0] ex, input logic sign);
    issue(tag, a, b, rm);
    waitValid(tag, lat);
    expectResult(tag, flags, sig, ex, sign, rm);
    finishOp(tag);
  endtask

  int holdBad;
  int seenValid;

  initial begin
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    check("reset in_ready", in_ready, 1'b1);
    check("reset out_valid", out_valid, 1'b0);
    expectResult("reset", 5'b00000, 25'h0, 10'h000, 1'b0, 5'h00);

    runOp("6/2", 32'h40C00000, 32'h40000000, 5'h03, 25, 5'b00000, 25'h1000000, 10'h001, 1'b0);
    runOp("1/3", 32'h3F800000, 32'h40400000, 5'h00, 25, 5'b00000, 25'h0AAAAAB, 10'h3FE, 1'b0);
    runOp("max/minnorm", 32'h7F7FFFFF, 32'h00800000, 5'h02, 25, 5'b00000, 25'h1FFFFFC, 10'h0FD, 1'b0);

    runOp("1/-0", 32'h3F800000, 32'h80000000, 5'h01, 1, 5'b01100, 25'h0, 10'h000, 1'b1);
    runOp("0/0", 32'h00000000, 32'h00000000, 5'h00, 1, 5'b10001, 25'h0, 10'h000, 1'b0);
    runOp("sNaN/1", 32'h7F800001, 32'h3F800000, 5'h00, 1, 5'b10001, 25'h0, 10'h000, 1'b0);
    runOp("qNaN/1", 32'h7FC00000, 32'h3F800000, 5'h00, 1, 5'b00001, 25'h0, 10'h000, 1'b0);
    runOp("-inf/-inf", 32'hFF800000, 32'hFF800000, 5'h00, 1, 5'b10001, 25'h0, 10'h000, 1'b0);
    runOp("inf/2", 32'h7F800000, 32'h40000000, 5'h00, 1, 5'b00100, 25'h0, 10'h000, 1'b0);
    runOp("2/inf", 32'h40000000, 32'h7F800000, 5'h00, 1, 5'b00010, 25'h0, 10'h000, 1'b0);

`ifdef FP32_DIV_SUBNORM_EN
    runOp("subnorm/1", 32'h00000001, 32'h3F800000, 5'h00, 25, 5'b00000, 25'h0, 10'h36B, 1'b0);
`else
    runOp("subnorm/1", 32'h00000001, 32'h3F800000, 5'h00, 1, 5'b00010, 25'h0, 10'h000, 1'b0);
`endif

    // Backpressure: result must hold while a competing request waits at the input.
    issue("bp", 32'hC0E00000, 32'h40000000, 5'h04);
    waitValid("bp", 25);
    @(negedge clock);
    in_a     = 32'h3F800000;
    in_b     = 32'h3F800000;
    in_valid = 1'b1;
    holdBad  = 0;
    repeat (10) begin
      @(posedge clock);
      #1;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) holdBad++;
    end
    in_valid = 1'b0;
    check("bp hold", holdBad, 0);
    expectResult("bp", 5'b00000, 25'h1800000, 10'h001, 1'b1, 5'h04);
    finishOp("bp");

    // Reset during iteration discards the operation.
    issue("rst", 32'h3F800000, 32'h40400000, 5'h00);
    repeat (12) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    check("rst in_ready", in_ready, 1'b1);
    check("rst out_valid", out_valid, 1'b0);
    seenValid = 0;
    repeat (30) begin
      @(posedge clock);
      #1;
      if (out_valid !== 1'b0) seenValid++;
    end
    check("rst no result", seenValid, 0);

    runOp("3/-1.5", 32'h40400000, 32'hBFC00000, 5'h02, 25, 5'b00000, 25'h0, 10'h001, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
